dmem_bridge: RTL and testbench

Bridge between the single-cycle datapath's data-memory port and a variable-latency data memory using a valid/ready handshake. It sits directly downstream of the datapath.
- Captures each load/store issued by the core and drives it to memory as a request.
- Stalls the core until the response arrives.
- Returns load data on `DM_readData`.
- Enforces a response timeout, so a hung memory cannot deadlock the processor.

---
 rtl/dmem_bridge_pkg.sv | 15 +
 rtl/dmem_bridge_if.sv | 35 +++
 rtl/dmem_bridge_timeout.sv | 33 +++
 rtl/dmem_bridge.sv | 147 ++++++++++++++
 tb/tb_dmem_bridge.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/dmem_bridge_pkg.sv
// dmem_bridge_pkg: shared types and constants for the data-memory bridge.
// Holds the FSM state enum, timeout counter width and default TIMEOUT.
package dmem_bridge_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam int CNT_W       = 8;
   localparam int TIMEOUT_DEF = 255;

endpackage

// File: rtl/dmem_bridge_if.sv
// dmem_bridge_if: valid/ready request bus plus response pulse to memory.
// master = bridge side (drives request), slave = memory side.
interface dmem_bridge_if #(
   parameter int N = 64
);

   logic         mem_req_valid;
   logic         mem_req_ready;
   logic         mem_req_write;
   logic [N-1:0] mem_req_addr;
   logic [N-1:0] mem_req_wdata;
   logic         mem_resp_valid;
   logic [N-1:0] mem_resp_rdata;

   modport master (
      output mem_req_valid,
      output mem_req_write,
      output mem_req_addr,
      output mem_req_wdata,
      input  mem_req_ready,
      input  mem_resp_valid,
      input  mem_resp_rdata
   );

   modport slave (
      input  mem_req_valid,
      input  mem_req_write,
      input  mem_req_addr,
      input  mem_req_wdata,
      output mem_req_ready,
      output mem_resp_valid,
      output mem_resp_rdata
   );

endinterface

// File: rtl/dmem_bridge_timeout.sv
// dmem_timeout: clearable 8-bit saturating cycle counter with expired flag.
// Ports: clk, reset (async active-low), clear, inc -> expired.
module dmem_timeout
   import dmem_bridge_pkg::*;
#(
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic inc,
   output logic expired
);

   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (inc && cnt != '1) begin
         cnt <= cnt + 1'b1;
      end
   end

   // >= rather than == so an acceptance exactly at the limit
   // cannot leave WAIT without any further way to time out.
   assign expired = (cnt >= LIMIT);

endmodule

// File: rtl/dmem_bridge.sv
// dmem_bridge: stalls the core while a load/store runs on a valid/ready
// memory bus; returns registered load data; faults on timeout.
// Ports: clk, reset (async active-low), DM_addr/DM_writeData/
// DM_writeEnable/DM_readEnable in; DM_readData, stall, mem_fault out;
// bus (dmem_bridge_if.master) carries mem_req_* / mem_resp_*.
// Option: DMEM_BRIDGE_ALIGN_CHECK_EN faults misaligned accesses in IDLE.
module dmem_bridge
   import dmem_bridge_pkg::*;
#(
   parameter int N       = 64,
   parameter int TIMEOUT = TIMEOUT_DEF
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] DM_addr,
   input  logic [N-1:0] DM_writeData,
   input  logic         DM_writeEnable,
   input  logic         DM_readEnable,
   output logic [N-1:0] DM_readData,
   output logic         stall,
   output logic         mem_fault,
   dmem_bridge_if.master bus
);

   state_t state, nxt;

   logic         access;
   logic         misalign;
   logic         expired;
   logic         accept;
   logic         resp;
   logic         start;
   logic         load_rd;
   logic         zero_rd;
   logic         fault_nxt;
   logic         stall_c;
   logic         write_q;
   logic [N-1:0] addr_q;
   logic [N-1:0] wdata_q;
   logic [N-1:0] rdata_q;
   logic         fault_q;

   assign access = DM_readEnable | DM_writeEnable;

`ifdef DMEM_BRIDGE_ALIGN_CHECK_EN
   assign misalign = |DM_addr[2:0];
`else
   assign misalign = 1'b0;
`endif

   assign accept = (state == REQ) && bus.mem_req_ready;
   assign resp   = (state == WAIT) && bus.mem_resp_valid;

   dmem_timeout #(
      .TIMEOUT(TIMEOUT)
   ) u_timeout (
      .clk    (clk),
      .reset  (reset),
      .clear  (start),
      .inc    ((state == REQ) || (state == WAIT)),
      .expired(expired)
   );

   always_comb begin
      nxt       = state;
      stall_c   = 1'b0;
      start     = 1'b0;
      load_rd   = 1'b0;
      zero_rd   = 1'b0;
      fault_nxt = 1'b0;
      unique case (state)
         IDLE: begin
            stall_c = access;
            if (access) begin
               if (misalign) begin
                  nxt       = DONE;
                  fault_nxt = 1'b1;
                  zero_rd   = 1'b1;
               end else begin
                  nxt   = REQ;
                  start = 1'b1;
               end
            end
         end
         REQ: begin
            stall_c = 1'b1;
            if (accept) begin
               nxt = WAIT;
            end else if (expired) begin
               nxt       = DONE;
               fault_nxt = 1'b1;
               zero_rd   = 1'b1;
            end
         end
         WAIT: begin
            stall_c = 1'b1;
            if (resp) begin
               nxt     = DONE;
               load_rd = !write_q;
            end else if (expired) begin
               nxt       = DONE;
               fault_nxt = 1'b1;
               zero_rd   = 1'b1;
            end
         end
         DONE: begin
            // enables still belong to the finishing instruction
            nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         write_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         fault_q <= 1'b0;
      end else begin
         state   <= nxt;
         fault_q <= fault_nxt;
         if (start) begin
            write_q <= DM_writeEnable;
            addr_q  <= DM_addr;
            wdata_q <= DM_writeData;
         end
         if (zero_rd) begin
            rdata_q <= '0;
         end else if (load_rd) begin
            rdata_q <= bus.mem_resp_rdata;
         end
      end
   end

   // IDLE stall is combinational from the enables; gate it so
   // every output reads 0 while reset is held.
   assign stall             = stall_c & reset;
   assign mem_fault         = fault_q;
   assign DM_readData       = rdata_q;
   assign bus.mem_req_valid = (state == REQ);
   assign bus.mem_req_write = write_q;
   assign bus.mem_req_addr  = addr_q;
   assign bus.mem_req_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge: directed + randomized accesses against a
// cycle-count/outcome model of the bridge; TIMEOUT = 10.
module tb_dmem_bridge;

   localparam int N = 64;
   localparam int T = 10;
`ifdef DMEM_BRIDGE_ALIGN_CHECK_EN
   localparam bit ALIGN = 1'b1;
`else
   localparam bit ALIGN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic [N-1:0] DM_addr = '0;
   logic [N-1:0] DM_writeData = '0;
   logic         DM_writeEnable = 1'b0;
   logic         DM_readEnable = 1'b0;
   logic [N-1:0] DM_readData;
   logic         stall;
   logic         mem_fault;

   dmem_bridge_if #(.N(N)) bus ();

   dmem_bridge #(
      .N      (N),
      .TIMEOUT(T)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .DM_addr       (DM_addr),
      .DM_writeData  (DM_writeData),
      .DM_writeEnable(DM_writeEnable),
      .DM_readEnable (DM_readEnable),
      .DM_readData   (DM_readData),
      .stall         (stall),
      .mem_fault     (mem_fault),
      .bus           (bus)
   );

   always #5 clk = ~clk;

   int vec = 0;
   int bad = 0;
   logic [63:0] mem_arr [logic [63:0]];
   logic [63:0] exp_rd = '0;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      vec++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] mem_rd(input logic [63:0] a);
      if (mem_arr.exists(a)) return mem_arr[a];
      return {a[31:0] ^ 32'h5a5a0f0f, ~a[31:0]};
   endfunction

   // d: cycles of REQ before ready; r: response delay after accept
   task automatic access(input bit we, input bit re,
                         input logic [63:0] a, input logic [63:0] wd,
                         input int d, input int r, input bit hung);
      bit          mis;
      int          e_stall, e_valid;
      bit          e_fault;
      logic [63:0] e_rd, ldval;
      int          cyc, n_stall, n_valid, due;
      bit          done;

      mis   = ALIGN && (a[2:0] != 3'd0);
      ldval = mem_rd(a);
      if (mis) begin
         e_stall = 1; e_valid = 0; e_fault = 1'b1; e_rd = '0;
      end else if (hung) begin
         e_stall = T + 2; e_valid = T + 1; e_fault = 1'b1; e_rd = '0;
      end else if (d + r <= T) begin
         e_stall = d + r + 2; e_valid = d + 1; e_fault = 1'b0;
         e_rd = we ? exp_rd : ldval;
      end else begin
         e_stall = T + 2; e_valid = d + 1; e_fault = 1'b1; e_rd = '0;
      end
      exp_rd = e_rd;

      cyc = 0; n_stall = 0; n_valid = 0; due = -1; done = 1'b0;
      @(posedge clk); #1;
      DM_addr = a; DM_writeData = wd;
      DM_writeEnable = we; DM_readEnable = re;
      while (!done && cyc < 40) begin
         bus.mem_req_ready  = bus.mem_req_valid && !hung && (n_valid == d);
         bus.mem_resp_valid = (cyc == due);
         bus.mem_resp_rdata = (cyc == due && !we) ? ldval
                              : {$urandom, $urandom};
         @(negedge clk);
         if (bus.mem_req_valid) begin
            chk("req_write", bus.mem_req_write, we);
            chk("req_addr", bus.mem_req_addr, a);
            if (we) chk("req_wdata", bus.mem_req_wdata, wd);
            if (bus.mem_req_ready) begin
               due = cyc + r;
               if (we) mem_arr[a] = wd;
            end
            n_valid++;
         end
         if (stall) begin
            n_stall++;
         end else begin
            done = 1'b1;
            chk("stall_cycles", n_stall, e_stall);
            chk("valid_cycles", n_valid, e_valid);
            chk("done_fault", mem_fault, e_fault);
            chk("done_rdata", DM_readData, e_rd);
         end
         @(posedge clk); #1;
         cyc++;
      end
      if (!done) chk("done_reached", 0, 1);
      DM_writeEnable = 1'b0; DM_readEnable = 1'b0;
      bus.mem_req_ready = 1'b0;
      for (int k = 0; k < 8; k++) begin
         bus.mem_resp_valid = (cyc == due);
         @(negedge clk);
         if (k < 3) begin
            chk("idle_stall", stall, 0);
            chk("idle_valid", bus.mem_req_valid, 0);
            chk("idle_fault", mem_fault, 0);
         end
         chk("idle_rdata", DM_readData, exp_rd);
         @(posedge clk); #1;
         cyc++;
      end
      bus.mem_resp_valid = 1'b0;
   endtask

   initial begin
      bus.mem_req_ready  = 1'b0;
      bus.mem_resp_valid = 1'b0;
      bus.mem_resp_rdata = '0;
      mem_arr[64'h40] = 64'h1122334455667788;
      #2;
      chk("rst_stall", stall, 0);
      chk("rst_valid", bus.mem_req_valid, 0);
      chk("rst_fault", mem_fault, 0);
      chk("rst_rdata", DM_readData, 0);
      @(negedge clk); reset = 1'b1;

      access(0, 1, 64'h40, 0, 0, 1, 0);
      access(1, 0, 64'h80, 64'hDEAD, 5, 1, 0);
      access(0, 1, 64'h80, 0, 0, 2, 0);
      access(0, 1, 64'h48, 0, 0, 1, 1);
      access(0, 1, 64'h40, 0, T - 1, 1, 0);
      access(0, 1, 64'h40, 0, 2, T - 1, 0);
      access(1, 1, 64'h10, 64'h5555AAAA, 1, 2, 0);
      access(0, 1, 64'h44, 0, 0, 1, 0);
      access(0, 1, 64'h40, 0, 0, 1, 0);

      // reset in WAIT, then a late response pulse
      @(posedge clk); #1;
      DM_addr = 64'h40; DM_readEnable = 1'b1;
      @(posedge clk); #1;
      bus.mem_req_ready = 1'b1;
      @(posedge clk); #1;
      bus.mem_req_ready = 1'b0;
      #2 reset = 1'b0;
      #1;
      chk("mid_rst_stall", stall, 0);
      chk("mid_rst_valid", bus.mem_req_valid, 0);
      chk("mid_rst_fault", mem_fault, 0);
      chk("mid_rst_rdata", DM_readData, 0);
      chk("mid_rst_write", bus.mem_req_write, 0);
      chk("mid_rst_addr", bus.mem_req_addr, 0);
      DM_readEnable = 1'b0;
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;
      bus.mem_resp_valid = 1'b1;
      bus.mem_resp_rdata = 64'hCAFEF00DCAFEF00D;
      @(posedge clk); #1;
      bus.mem_resp_valid = 1'b0;
      exp_rd = '0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("post_rst_stall", stall, 0);
         chk("post_rst_rdata", DM_readData, 0);
         chk("post_rst_fault", mem_fault, 0);
      end
      access(0, 1, 64'h40, 0, 0, 1, 0);

      for (int i = 0; i < 40; i++) begin
         bit          we, re, hung;
         logic [63:0] a, wd;
         we   = 1'($urandom_range(0, 1));
         re   = we ? 1'($urandom_range(0, 1)) : 1'b1;
         a    = 64'($urandom_range(0, 15)) << 3;
         if ($urandom_range(0, 5) == 0) a[2:0] = 3'($urandom_range(1, 7));
         wd   = {$urandom, $urandom};
         hung = ($urandom_range(0, 7) == 0);
         access(we, re, a, wd, $urandom_range(0, T - 1),
                $urandom_range(1, 6), hung);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
      $finish;
   end

endmodule
